// File: rtl/lifo_package.sv
// Shared types for the lifo datapath and its front-end arbiter.
package lifo_package;

   typedef enum logic { PUSH = 1'b0, POP = 1'b1 } lifo_op_t;

   typedef enum logic [2:0] {
      LIFO_BASIC,
      LIFO_FULL,
      LIFO_EMPTY,
      ARB_RR,
      ARB_BOUNDARY
   } test_case;

endpackage

// File: rtl/lifo_arbiter_if.sv
// Requester-side bus of lifo_arbiter: per-requester valid/op/data, grant and pop response.
interface lifo_arbiter_if
   import lifo_package::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DWIDTH = 16
);

   logic     [N_REQ-1:0]        req_valid;
   lifo_op_t [N_REQ-1:0]        req_op;
   logic     [N_REQ*DWIDTH-1:0] req_data;
   logic     [N_REQ-1:0]        req_ready;
   logic     [N_REQ-1:0]        rsp_valid;
   logic     [DWIDTH-1:0]       rsp_data;

   modport master (
      output req_valid, req_op, req_data,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_data,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic          found;
   int unsigned   j;
   logic [IW-1:0] jj;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         j  = (32'(ptr_i) + k) % N;
         jj = IW'(j);
         if (!found && req_i[jj]) begin
            found     = 1'b1;
            gnt_o[jj] = 1'b1;
            idx_o     = jj;
         end
      end
   end

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one lifo between N_REQ requesters: round-robin grant, shadow occupancy count,
// registered lifo commands and a two-stage id pipeline that steers pop data back.
module lifo_arbiter
   import lifo_package::*;
#(
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned AWIDTH = 8,
   parameter int unsigned N_REQ  = 4
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   lifo_arbiter_if.slave       req_if,
   output logic                lifo_wrreq_o,
   output logic [DWIDTH-1:0]   lifo_data_o,
   output logic                lifo_rdreq_o,
   input  logic [DWIDTH-1:0]   lifo_q_i,
   input  logic                lifo_full_i,
   input  logic                lifo_empty_i,
   output logic [AWIDTH:0]     usedw_o,
   output logic                err_o
);

   localparam int unsigned     IW    = $clog2(N_REQ);
   localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

   logic [AWIDTH:0]    cnt_q;
   logic [IW-1:0]      ptr_q;
   logic [N_REQ-1:0]   elig;
   logic [N_REQ-1:0]   gnt;
   logic [IW-1:0]      gnt_idx;
   logic               hs;
   logic               gnt_pop;
   logic               wr_q;
   logic               rd_q;
   logic               rsp_q;
   logic [DWIDTH-1:0]  data_q;
   logic [IW-1:0]      id1_q;
   logic [IW-1:0]      id2_q;
   logic               err_q;

   // Eligibility uses the shadow count, so a blocked op never stalls the others.
   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         elig[i] = req_if.req_valid[i] &&
                   ((req_if.req_op[i] == POP) ? (cnt_q != '0) : (cnt_q != DEPTH));
      end
   end

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr (
      .req_i (elig),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   assign req_if.req_ready = gnt & {N_REQ{rst_n_i}};
   assign hs               = |gnt;
   assign gnt_pop          = (req_if.req_op[gnt_idx] == POP);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q  <= '0;
         ptr_q  <= '0;
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         rsp_q  <= 1'b0;
         data_q <= '0;
         id1_q  <= '0;
         id2_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         wr_q  <= hs && !gnt_pop;
         rd_q  <= hs && gnt_pop;
         id1_q <= gnt_idx;
         rsp_q <= rd_q;
         id2_q <= id1_q;
         err_q <= err_q | (wr_q & lifo_full_i) | (rd_q & lifo_empty_i);
         if (hs) begin
            ptr_q <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (gnt_pop) begin
               cnt_q <= cnt_q - 1'b1;
            end else begin
               cnt_q  <= cnt_q + 1'b1;
               data_q <= req_if.req_data[gnt_idx*DWIDTH +: DWIDTH];
            end
         end
      end
   end

   always_comb begin
      req_if.rsp_valid = '0;
      if (rsp_q) req_if.rsp_valid[id2_q] = 1'b1;
   end

   assign req_if.rsp_data = lifo_q_i;
   assign lifo_wrreq_o    = wr_q;
   assign lifo_rdreq_o    = rd_q;
   assign lifo_data_o     = data_q;
   assign usedw_o         = cnt_q;
   assign err_o           = err_q;

endmodule
